// File: rtl/bram_stream_reader_if.sv
// Stream interface between the BRAM reader and its consumer.
// The reader drives the word, its valid and last flags; the consumer drives ready.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Sequential BRAM read engine: walks base_addr..base_addr+length-1 (mod 2^ADDR_WIDTH)
// on a 1-cycle-latency read port and streams the words out through a 2-entry FIFO.
// A read is issued only when the word it returns is guaranteed a FIFO slot, so
// downstream backpressure never drops or duplicates data.
module bram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  b_en,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_dout,
    bram_stream_reader_if.master  m
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [ADDR_WIDTH-1:0] last_addr_r;
    logic [ADDR_WIDTH:0]   issue_cnt_r;
    logic [ADDR_WIDTH:0]   out_cnt_r;
    logic                  inflight_r;
    logic [DATA_WIDTH-1:0] fifo_mem_r [0:1];
    logic                  wr_idx_r;
    logic                  rd_idx_r;
    logic [1:0]            count_r;

    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic [2:0]            occupancy_s;

    // Issue decision: a new read may go out only if the FIFO, after this cycle's
    // push and pop, still has room for the word the read returns next cycle.
    always_comb begin
        pop_s       = 1'b0;
        push_s      = 1'b0;
        issue_s     = 1'b0;
        occupancy_s = 3'd0;
        pop_s       = (count_r != 2'd0) & m.m_ready;
        push_s      = inflight_r;
        occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        if ((state_r == READ) && (issue_cnt_r != {(ADDR_WIDTH+1){1'b0}}) && (occupancy_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    assign busy      = (state_r == READ);
    assign done      = (state_r == DONE);
    assign b_en      = issue_s;
    assign b_addr    = issue_s ? ptr_r : last_addr_r;
    assign m.m_valid = (count_r != 2'd0);
    assign m.m_data  = fifo_mem_r[rd_idx_r];
    assign m.m_last  = (count_r != 2'd0) && (out_cnt_r == CNT_ONE);

    // Command FSM, read pointer/counters, in-flight tracking and output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            ptr_r         <= {ADDR_WIDTH{1'b0}};
            last_addr_r   <= {ADDR_WIDTH{1'b0}};
            issue_cnt_r   <= {(ADDR_WIDTH+1){1'b0}};
            out_cnt_r     <= {(ADDR_WIDTH+1){1'b0}};
            inflight_r    <= 1'b0;
            fifo_mem_r[0] <= {DATA_WIDTH{1'b0}};
            fifo_mem_r[1] <= {DATA_WIDTH{1'b0}};
            wr_idx_r      <= 1'b0;
            rd_idx_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            inflight_r <= issue_s;
            count_r    <= count_r + {1'b0, push_s} - {1'b0, pop_s};
            if (push_s) begin
                fifo_mem_r[wr_idx_r] <= b_dout;
                wr_idx_r             <= ~wr_idx_r;
            end
            if (pop_s) begin
                rd_idx_r <= ~rd_idx_r;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        ptr_r       <= base_addr;
                        issue_cnt_r <= length;
                        out_cnt_r   <= length;
                        state_r     <= (length != {(ADDR_WIDTH+1){1'b0}}) ? READ : DONE;
                    end
                end
                READ: begin
                    if (issue_s) begin
                        last_addr_r <= ptr_r;
                        ptr_r       <= ptr_r + PTR_ONE;
                        issue_cnt_r <= issue_cnt_r - CNT_ONE;
                    end
                    if (pop_s) begin
                        out_cnt_r <= out_cnt_r - CNT_ONE;
                        if (out_cnt_r == CNT_ONE) begin
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
